// File: rtl/servo_pkg.sv
// Shared types, default timing constants and pulse-width helper for the wheel servo PWM driver.
package servo_pkg;

  localparam int CMD_W             = 8;
  localparam int DEF_CLK_HZ        = 100_000_000;
  localparam int DEF_FRAME_US      = 20000;
  localparam int DEF_PULSE_BASE_US = 1000;
  localparam int DEF_STEP_US       = 4;
  localparam int DEF_SLEW_STEP     = 16;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_PULSE,
    ST_GAP
  } ch_state_e;

  // Pulse width in microseconds; 32-bit result so no command can overflow it.
  function automatic logic [31:0] pulse_width(input logic [CMD_W-1:0] cmd,
                                              input int base_us,
                                              input int step_us);
    return 32'(base_us) + 32'(cmd) * 32'(step_us);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One wheel channel: frame-boundary command latch, optional slew limit (SERVO_SLEW_LIMIT_EN)
// and the OFF/PULSE/GAP state machine producing a registered PWM output.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int FC_W          = 15,
  parameter int PULSE_BASE_US = DEF_PULSE_BASE_US,
  parameter int STEP_US       = DEF_STEP_US,
  parameter int SLEW_STEP     = DEF_SLEW_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             frame_start,
  input  logic [FC_W-1:0]  frame_cnt,
  input  logic [CMD_W-1:0] cmd,
  output logic             pwm
);

  localparam logic [CMD_W-1:0] SLEW_C = CMD_W'(SLEW_STEP);

  ch_state_e        state, state_nxt;
  logic [CMD_W-1:0] cmd_app, cmd_nxt;
  logic             tick_q;
  logic [31:0]      width_us;
  logic             width_hit;

  // Move toward the target by at most SLEW_C; a zero target stops at once.
  function automatic logic [CMD_W-1:0] slew_sat(input logic [CMD_W-1:0] cur,
                                                input logic [CMD_W-1:0] tgt);
    logic [CMD_W-1:0] diff;
    if (tgt == '0) return '0;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > SLEW_C) ? cur + SLEW_C : tgt;
    end
    diff = cur - tgt;
    return (diff > SLEW_C) ? cur - SLEW_C : tgt;
  endfunction

  assign width_us  = pulse_width(cmd_app, PULSE_BASE_US, STEP_US);
  // frame_cnt lands on the width one cycle after the tick, which keeps the
  // high time aligned with the rise that follows frame_start.
  assign width_hit = tick_q && ({{(32-FC_W){1'b0}}, frame_cnt} == width_us);

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_app;
    if (frame_start) begin
`ifdef SERVO_SLEW_LIMIT_EN
      cmd_nxt = slew_sat(cmd_app, cmd);
`else
      cmd_nxt = cmd;
`endif
      state_nxt = (cmd_nxt != '0) ? ST_PULSE : ST_OFF;
    end else begin
      case (state)
        ST_PULSE: if (width_hit) state_nxt = ST_GAP;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_OFF;
      cmd_app <= '0;
      tick_q  <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmd_app <= cmd_nxt;
      tick_q  <= tick;
      pwm     <= (state_nxt == ST_PULSE);
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Two-channel hobby-servo PWM driver: 1 us prescaler, shared frame counter, one channel per wheel.
// Optional slew limiting of applied commands is enabled with SERVO_SLEW_LIMIT_EN.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int FRAME_US      = DEF_FRAME_US,
  parameter int PULSE_BASE_US = DEF_PULSE_BASE_US,
  parameter int STEP_US       = DEF_STEP_US,
  parameter int SLEW_STEP     = DEF_SLEW_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_l,
  input  logic [CMD_W-1:0] cmd_r,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             frame_start
);

  localparam int PRE_DIV = CLK_HZ / 1_000_000;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int FC_W    = $clog2(FRAME_US);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);
  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FRAME_US - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [FC_W-1:0]  frame_cnt;
  logic             tick;
  logic             frame_wrap;

  assign tick       = (pre_cnt == PRE_MAX);
  assign frame_wrap = tick && (frame_cnt == FC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt     <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
      frame_start <= frame_wrap;
    end
  end

  servo_pwm_channel #(
    .FC_W          (FC_W),
    .PULSE_BASE_US (PULSE_BASE_US),
    .STEP_US       (STEP_US),
    .SLEW_STEP     (SLEW_STEP)
  ) u_ch_l (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .cmd         (cmd_l),
    .pwm         (pwm_l)
  );

  servo_pwm_channel #(
    .FC_W          (FC_W),
    .PULSE_BASE_US (PULSE_BASE_US),
    .STEP_US       (STEP_US),
    .SLEW_STEP     (SLEW_STEP)
  ) u_ch_r (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .cmd         (cmd_r),
    .pwm         (pwm_r)
  );

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench for servo_pwm_driver on a scaled time base (2 clocks/us, 400 us frame).
module tb_servo_pwm_driver;
  import servo_pkg::*;

  localparam int CLK_HZ = 2_000_000;
  localparam int FRAME  = 400;
  localparam int BASE   = 100;
  localparam int STEP   = 1;
  localparam int SLEW   = 16;
  localparam int P      = CLK_HZ / 1_000_000;
  localparam int N      = FRAME * P;

`ifdef SERVO_SLEW_LIMIT_EN
  localparam int EXP_A_L = 232, EXP_B_L = 264, EXP_C_L = 232, EXP_C_R = 232;
  localparam int EXP_E_L = 232, EXP_F_L = 264;
`else
  localparam int EXP_A_L = 456, EXP_B_L = 710, EXP_C_L = 202, EXP_C_R = 710;
  localparam int EXP_E_L = 456, EXP_F_L = 456;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cmd_l = 8'd0;
  logic [7:0] cmd_r = 8'd0;
  logic       pwm_l, pwm_r, frame_start;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .CLK_HZ        (CLK_HZ),
    .FRAME_US      (FRAME),
    .PULSE_BASE_US (BASE),
    .STEP_US       (STEP),
    .SLEW_STEP     (SLEW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_l       (cmd_l),
    .cmd_r       (cmd_r),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: applied command per frame and the time since reset release.
  int         t = 0;
  logic [7:0] app_l = 8'd0;
  logic [7:0] app_r = 8'd0;

  function automatic logic [7:0] next_app(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef SERVO_SLEW_LIMIT_EN
    int c, g;
    c = int'(cur);
    g = int'(tgt);
    if (g == 0) return 8'd0;
    if (g > c) return (g - c > SLEW) ? 8'(c + SLEW) : tgt;
    return (c - g > SLEW) ? 8'(c - SLEW) : tgt;
`else
    logic [7:0] unused_cur;
    unused_cur = cur;
    return tgt;
`endif
  endfunction

  function automatic bit exp_pwm(input int tt, input logic [7:0] a);
    if (tt <= N || a == 8'd0) return 1'b0;
    return ((tt - 1) % N) < (BASE + int'(a) * STEP) * P;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      t = 0;
      app_l = 8'd0;
      app_r = 8'd0;
      check("model_rst_pwm_l", pwm_l, 0);
      check("model_rst_pwm_r", pwm_r, 0);
      check("model_rst_frame_start", frame_start, 0);
    end else begin
      t++;
      if (t > N && (t % N) == 1) begin
        app_l = next_app(app_l, cmd_l);
        app_r = next_app(app_r, cmd_r);
      end
      check("model_frame_start", frame_start, (t % N) == 0);
      check("model_pwm_l", pwm_l, exp_pwm(t, app_l));
      check("model_pwm_r", pwm_r, exp_pwm(t, app_r));
    end
  end

  // Counts edges from reset release to the first frame_start; no pulse may appear meanwhile.
  task automatic wait_first_frame(input string tag);
    int edges = 0;
    int hi = 0;
    bit seen = 1'b0;
    while (!seen && edges < 2 * N) begin
      @(posedge clk);
      #2;
      edges++;
      if (frame_start) seen = 1'b1;
      else hi += int'(pwm_l) + int'(pwm_r);
    end
    check({tag, "_first_fs_edges"}, edges, N);
    check({tag, "_dead_frame_high"}, hi, 0);
  endtask

  // Runs one full frame starting from a frame_start cycle, optionally changing commands mid-frame.
  task automatic run_frame(input string tag, input int chg_at, input logic [7:0] nl,
                           input logic [7:0] nr, input int exp_l, input int exp_r);
    int hl = 0;
    int hr = 0;
    bit rise_l = 1'b0;
    bit rise_r = 1'b0;
    bit fs_end = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        cmd_l = nl;
        cmd_r = nr;
      end
      @(posedge clk);
      #2;
      if (i == 0) begin
        rise_l = pwm_l;
        rise_r = pwm_r;
      end
      if (i == N - 1) fs_end = frame_start;
      else begin
        hl += int'(pwm_l);
        hr += int'(pwm_r);
      end
    end
    check({tag, "_high_l"}, hl, exp_l);
    check({tag, "_high_r"}, hr, exp_r);
    check({tag, "_period"}, fs_end, 1);
    check({tag, "_rise_l"}, rise_l, exp_l != 0);
    check({tag, "_rise_r"}, rise_r, exp_r != 0);
  endtask

  initial begin
    if (!(BASE + 255 * STEP < FRAME)) begin
      $display("FAIL param_legality base=%0d step=%0d frame=%0d", BASE, STEP, FRAME);
      $fatal(1);
    end

    check("pkg_width_cmd1",   pulse_width(8'd1,   DEF_PULSE_BASE_US, DEF_STEP_US), 1004);
    check("pkg_width_cmd128", pulse_width(8'd128, DEF_PULSE_BASE_US, DEF_STEP_US), 1512);
    check("pkg_width_cmd255", pulse_width(8'd255, DEF_PULSE_BASE_US, DEF_STEP_US), 2020);

    cmd_l = 8'd128;
    cmd_r = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_pwm_l", pwm_l, 0);
    check("reset_pwm_r", pwm_r, 0);
    check("reset_frame_start", frame_start, 0);
    rst = 1'b1;

    wait_first_frame("boot");
    run_frame("mid_scale_chg", 100, 8'd255, 8'd0, EXP_A_L, 0);
    run_frame("after_chg", 10, 8'd1, 8'd255, EXP_B_L, 0);
    run_frame("extremes", -1, 8'd1, 8'd255, EXP_C_L, EXP_C_R);

    repeat (50) @(posedge clk);
    #2;
    check("pre_reset_pwm_l", pwm_l, 1);
    check("pre_reset_pwm_r", pwm_r, 1);
    @(negedge clk);
    rst = 1'b0;
    cmd_l = 8'd128;
    cmd_r = 8'd0;
    #1;
    check("async_rst_pwm_l", pwm_l, 0);
    check("async_rst_pwm_r", pwm_r, 0);
    check("async_rst_frame_start", frame_start, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    wait_first_frame("rerun");
    run_frame("zero_r_1", -1, 8'd128, 8'd0, EXP_E_L, 0);
    run_frame("zero_r_2", 10, 8'd0, 8'd0, EXP_F_L, 0);
    run_frame("stop_both", 10, 8'h10, 8'd0, 0, 0);
    run_frame("cmd_0x10", 10, 8'hF0, 8'd0, (BASE + 16) * P, 0);
`ifdef SERVO_SLEW_LIMIT_EN
    for (int a = 32; a <= 240; a += 16)
      run_frame($sformatf("slew_%0h", a), (a == 240) ? 10 : -1, 8'd0, 8'd0, (BASE + a) * P, 0);
    run_frame("slew_estop", -1, 8'd0, 8'd0, 0, 0);
`else
    run_frame("cmd_0xf0", -1, 8'hF0, 8'd0, 680, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Consumes the 8-bit left/right wheel speed commands produced by the line-follower steering logic.
- Converts them into two hobby-servo PWM signals, one per continuous-rotation wheel servo, driven to the Basys3 Pmod pins.
- Time base: shared 1 µs tick and fixed 20 ms frame. A new command is applied only at a frame boundary, so pulses are never truncated or glitched.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; must be an integer multiple of 1_000_000.
- FRAME_US, 20000, PWM frame period in µs.
- PULSE_BASE_US, 1000, pulse width for command 1 minus STEP_US.
- STEP_US, 4, µs of pulse width added per command LSB.
- SLEW_STEP, 16, maximum change of the applied command per frame; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_l  in  8  left servo command; 0 means off/no pulse
- cmd_r  in  8  right servo command; 0 means off/no pulse
- pwm_l  out  1  left servo PWM, registered
- pwm_r  out  1  right servo PWM, registered
- frame_start  out  1  one-cycle strobe marking the frame boundary

Behaviour:
- Reset (rst low, asynchronous):
  - pwm_l, pwm_r, frame_start = 0.
  - Prescaler, frame counter and applied commands = 0.
  - Takes effect immediately, including mid-pulse.
- Prescaler:
  - Counts 0..CLK_HZ/1e6-1.
  - tick = 1 in the cycle where the count equals its maximum; the count then wraps to 0.
- Frame counter (frame_cnt, width clog2(FRAME_US)):
  - Increments on tick.
  - When tick and frame_cnt == FRAME_US-1, it wraps to 0 and frame_start is asserted in that same cycle, registered.
- Command latch:
  - On the frame_start edge, each channel's applied command cmd_app <= cmd_x.
  - cmd_x is sampled in that cycle only; mid-frame changes are ignored until the next boundary.
- Width: width = PULSE_BASE_US + cmd_app*STEP_US, computed at frame-counter width, no overflow. Defaults give 1004..2020 µs.
- Per-channel FSM (OFF, PULSE, GAP):
  - At a boundary the channel enters PULSE if the new cmd_app != 0, else OFF.
  - PULSE: pwm = 1; moves to GAP on the tick at which frame_cnt reaches width.
  - GAP and OFF: pwm = 0 until the next boundary.
- Timing:
  - pwm rises in the cycle after frame_start.
  - High time is exactly width*(CLK_HZ/1e6) clocks.
  - Period is exactly FRAME_US*(CLK_HZ/1e6) clocks.
- Channels are independent; both rise in the same cycle.
- After reset, the first frame is dead (cmd_app = 0, no pulse). The first frame_start occurs FRAME_US*(CLK_HZ/1e6) clocks after reset release.
- Parameter legality: PULSE_BASE_US + 255*STEP_US < FRAME_US; the bench checks this at elaboration.

Optional Feature:
- Macro: SERVO_SLEW_LIMIT_EN.
- Defined:
  - At each boundary, cmd_app moves toward cmd_x by at most SLEW_STEP, saturating at the target.
  - A command of 0 is applied immediately (emergency stop).
  - Leaving 0 starts from 0 and ramps up.
- Undefined: cmd_app = cmd_x directly at each boundary; SLEW_STEP is unused.

Decomposition:
- Package servo_pkg:
  - CMD_W = 8.
  - Channel state enum (OFF, PULSE, GAP).
  - Default timing constants.
  - Helper function computing width from command.
- Sub-module servo_pwm_channel:
  - One per wheel.
  - Holds cmd_app, slew logic and the FSM.
  - Takes tick, frame_start, frame_cnt and cmd; outputs pwm.
- The top level holds the prescaler and frame counter and instantiates two channels.

Test Plan:
- Reset: assert rst low mid-pulse.
  - pwm_l/pwm_r go to 0 within the same cycle.
  - After release, no pulse in the first frame.
  - frame_start first asserts 2,000,000 clocks after release.
- Mid-scale command: cmd_l = 128.
  - Each following frame, pwm_l is high for exactly 151,200 clocks (1512 µs) with a period of 2,000,000 clocks.
- Command change mid-frame: cmd_l goes 128 -> 255 at 500 µs into a frame.
  - The current pulse stays 151,200 clocks.
  - The next frame pulse is 202,000 clocks.
- Zero command: cmd_r = 0.
  - pwm_r stays low for the whole frame.
  - pwm_l is unaffected; frame_start continues every 2,000,000 clocks.
- Extremes: cmd_l = 1, cmd_r = 255.
  - High times of 100,400 and 202,000 clocks.
  - Both rise on the cycle after frame_start.
- With SERVO_SLEW_LIMIT_EN: cmd_l steps 0x10 -> 0xF0.
  - Applied widths over successive frames follow 0x20, 0x30, ..., 0xF0.
  - Then cmd_l = 0 gives no pulse in the very next frame.
